// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - request/response sequencer for single-cycle ADD/SUB/INC/DEC,
// bit-serial shift-add MUL and restoring DIV on a WORD_SIZE datapath.
package opcodes;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_INC = 5'd4;
  localparam logic [4:0] OP_DEC = 5'd5;
endpackage

module arith_sequencer
  import opcodes::*;
#(
  parameter int WORD_SIZE    = 19,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] req_opcode,
  input  logic [WORD_SIZE-1:0]    req_op_a,
  input  logic [WORD_SIZE-1:0]    req_op_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WORD_SIZE-1:0]    rsp_result,
  output logic [WORD_SIZE-1:0]    rsp_remainder,
  output logic                    rsp_error,
  output logic                    busy
);

  localparam int CW = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, RESP} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] mcand_q, mcand_d;
  logic [WORD_SIZE-1:0] mplier_q, mplier_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0] quot_q, quot_d;
  logic [WORD_SIZE-1:0] divisor_q, divisor_d;
  logic [WORD_SIZE-1:0] rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [WORD_SIZE-1:0] remainder_q, remainder_d;
  logic                 error_q, error_d;
  logic                 valid_q, valid_d;

  logic                 accept;
  logic                 last_iter;
  logic                 op_single, op_mul, op_div, div_zero;
  logic [WORD_SIZE-1:0] single_res;
  logic [WORD_SIZE-1:0] acc_nx, quot_nx, rem_nx;
  logic [WORD_SIZE:0]   rem_shift;
  logic                 rem_ge;

  assign accept    = req_valid && req_ready;
  assign last_iter = (cnt_q == '0);

  always_comb begin : decode
    op_single  = 1'b0;
    op_mul     = 1'b0;
    op_div     = 1'b0;
    single_res = '0;
    div_zero   = (req_op_b == '0);
    case (req_opcode)
      OPCODE_WIDTH'(OP_ADD): begin op_single = 1'b1; single_res = req_op_a + req_op_b; end
      OPCODE_WIDTH'(OP_SUB): begin op_single = 1'b1; single_res = req_op_a - req_op_b; end
      OPCODE_WIDTH'(OP_INC): begin op_single = 1'b1; single_res = req_op_a + WORD_SIZE'(1); end
      OPCODE_WIDTH'(OP_DEC): begin op_single = 1'b1; single_res = req_op_a - WORD_SIZE'(1); end
      OPCODE_WIDTH'(OP_MUL): op_mul = 1'b1;
      OPCODE_WIDTH'(OP_DIV): op_div = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_mul)                  state_d = MUL_ITER;
          else if (op_div && !div_zero) state_d = DIV_ITER;
          else                         state_d = RESP;
        end
      end
      MUL_ITER: if (last_iter) state_d = RESP;
      DIV_ITER: if (last_iter) state_d = RESP;
      RESP:     if (valid_q && rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    req_ready     = (state_q == IDLE) && !rst;
    busy          = (state_q != IDLE);
    rsp_valid     = valid_q;
    rsp_result    = result_q;
    rsp_remainder = remainder_q;
    rsp_error     = error_q;
  end

  // Restoring step: the shifted partial remainder needs one extra bit before the compare.
  always_comb begin : datapath
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    quot_d      = quot_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    error_d     = error_q;
    valid_d     = valid_q;

    acc_nx    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_shift = {rem_q, quot_q[WORD_SIZE-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor_q});
    rem_nx    = rem_ge ? WORD_SIZE'(rem_shift - {1'b0, divisor_q}) : rem_shift[WORD_SIZE-1:0];
    quot_nx   = {quot_q[WORD_SIZE-2:0], rem_ge};

    case (state_q)
      IDLE: begin
        if (accept) begin
          result_d    = '0;
          remainder_d = '0;
          error_d     = 1'b0;
          if (op_mul) begin
            mcand_d  = req_op_a;
            mplier_d = req_op_b;
            acc_d    = '0;
            cnt_d    = CW'(WORD_SIZE - 1);
          end else if (op_div && !div_zero) begin
            quot_d    = req_op_a;
            divisor_d = req_op_b;
            rem_d     = '0;
            cnt_d     = CW'(WORD_SIZE - 1);
          end else if (op_div) begin
            result_d    = '1;
            remainder_d = req_op_a;
            error_d     = 1'b1;
            valid_d     = 1'b1;
          end else if (op_single) begin
            result_d = single_res;
            valid_d  = 1'b1;
          end else begin
            error_d = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      MUL_ITER: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (last_iter) begin
          result_d = acc_nx;
          valid_d  = 1'b1;
        end
      end
      DIV_ITER: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q - CW'(1);
        if (last_iter) begin
          result_d    = quot_nx;
          remainder_d = rem_nx;
          valid_d     = 1'b1;
        end
      end
      RESP: if (valid_q && rsp_ready) valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : datapath_reg
    if (rst) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      quot_q      <= quot_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_arith_sequencer.sv
// tb/tb_arith_sequencer.sv - self-checking bench for arith_sequencer: vector table,
// random ops against an arithmetic reference, and multi-cycle corner sequences.
module tb_arith_sequencer;
  import opcodes::*;

  localparam int W = 19;
  localparam logic [W-1:0] MASK = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [4:0]   req_opcode;
  logic [W-1:0] req_op_a;
  logic [W-1:0] req_op_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [W-1:0] rsp_remainder;
  logic         rsp_error;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  arith_sequencer #(.WORD_SIZE(W), .OPCODE_WIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opcode    (req_opcode),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_remainder (rsp_remainder),
    .rsp_error     (rsp_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference built from the arithmetic definitions, not from the datapath steps.
  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] rm, output logic e,
                       output int lat);
    longint unsigned p;
    r = '0; rm = '0; e = 1'b0; lat = 1;
    case (op)
      OP_ADD: r = W'((longint'(a) + longint'(b)) % (longint'(1) << W));
      OP_SUB: r = W'((longint'(a) - longint'(b) + (longint'(1) << W)) % (longint'(1) << W));
      OP_INC: r = W'((longint'(a) + 1) % (longint'(1) << W));
      OP_DEC: r = W'((longint'(a) + (longint'(1) << W) - 1) % (longint'(1) << W));
      OP_MUL: begin
        p   = longint'(a) * longint'(b);
        r   = W'(p % (longint'(1) << W));
        lat = W + 1;
      end
      OP_DIV: begin
        if (b == '0) begin
          r = MASK; rm = a; e = 1'b1;
        end else begin
          r = a / b; rm = a % b; lat = W + 1;
        end
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] rm, output logic e,
                       output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    req_opcode = op; req_op_a = a; req_op_b = b; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op_a  = W'($urandom);
    req_op_b  = W'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    r = rsp_result; rm = rsp_remainder; e = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] r, rm, er, erm;
    logic         e, ee;
    int           lat, elat, seen;
    logic [4:0]   op;
    logic [W-1:0] a, b;

    vecs[0]  = '{OP_ADD, 19'd3,      19'd4,     19'd7,      19'd0,      1'b0, 1};
    vecs[1]  = '{OP_SUB, 19'd5,      19'd7,     19'h7FFFE,  19'd0,      1'b0, 1};
    vecs[2]  = '{OP_MUL, 19'h7FFFF,  19'd2,     19'h7FFFE,  19'd0,      1'b0, 20};
    vecs[3]  = '{OP_MUL, 19'h00123,  19'h00045, 19'h04E6F,  19'd0,      1'b0, 20};
    vecs[4]  = '{OP_DIV, 19'd100,    19'd7,     19'd14,     19'd2,      1'b0, 20};
    vecs[5]  = '{OP_DIV, 19'h12345,  19'd0,     19'h7FFFF,  19'h12345,  1'b1, 1};
    vecs[6]  = '{OP_INC, 19'h7FFFF,  19'd9,     19'd0,      19'd0,      1'b0, 1};
    vecs[7]  = '{OP_DEC, 19'd0,      19'd9,     19'h7FFFF,  19'd0,      1'b0, 1};
    vecs[8]  = '{OP_ADD, 19'h7FFFF,  19'd1,     19'd0,      19'd0,      1'b0, 1};
    vecs[9]  = '{OP_DIV, 19'd5,      19'd9,     19'd0,      19'd5,      1'b0, 20};
    vecs[10] = '{OP_DIV, 19'h7FFFF,  19'd1,     19'h7FFFF,  19'd0,      1'b0, 20};
    vecs[11] = '{5'd31,  19'd77,     19'd88,    19'd0,      19'd0,      1'b1, 1};

    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_op_a = '0; req_op_b = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_result", 32'(rsp_result), 32'd0);
    check("reset_remainder", 32'(rsp_remainder), 32'd0);
    check("reset_error", 32'(rsp_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, rm, e, lat);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_remainder", i), 32'(rm), 32'(vecs[i].rem));
      check($sformatf("vec%0d_error", i), 32'(e), 32'(vecs[i].err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 40));
      model(op, a, b, er, erm, ee, elat);
      do_op(op, a, b, r, rm, e, lat);
      check($sformatf("rnd%0d_op%0d_result", i, op), 32'(r), 32'(er));
      check($sformatf("rnd%0d_op%0d_remainder", i, op), 32'(rm), 32'(erm));
      check($sformatf("rnd%0d_op%0d_error", i, op), 32'(e), 32'(ee));
      check($sformatf("rnd%0d_op%0d_latency", i, op), 32'(lat), 32'(elat));
    end

    // Response backpressure with a competing request.
    @(negedge clk);
    req_opcode = OP_INC; req_op_a = 19'h7FFFF; req_op_b = '0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = OP_ADD; req_op_a = 19'd1; req_op_b = 19'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", 32'(rsp_result), 32'd0);
      check("bp_error", 32'(rsp_error), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("bp_no_accept_busy", 32'(busy), 32'd0);

    // Reset during the 10th MUL iteration cycle.
    @(negedge clk);
    req_opcode = OP_MUL; req_op_a = 19'h00321; req_op_b = 19'h00107; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_result", 32'(rsp_result), 32'd0);
    check("abort_remainder", 32'(rsp_remainder), 32'd0);
    check("abort_error", 32'(rsp_error), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("abort_no_response", 32'(seen), 32'd0);
    do_op(OP_ADD, 19'd3, 19'd4, r, rm, e, lat);
    check("after_abort_add", 32'(r), 32'd7);
    check("after_abort_latency", 32'(lat), 32'd1);

    // Illegal opcode followed immediately by a held DEC request.
    @(negedge clk);
    req_opcode = 5'd17; req_op_a = 19'h55555; req_op_b = 19'h2AAAA; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("illegal_valid_lat1", 32'(rsp_valid), 32'd1);
    check("illegal_result", 32'(rsp_result), 32'd0);
    check("illegal_remainder", 32'(rsp_remainder), 32'd0);
    check("illegal_error", 32'(rsp_error), 32'd1);
    req_opcode = OP_DEC; req_op_a = 19'd0; req_op_b = 19'd3; req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    check("b2b_idle_valid", 32'(rsp_valid), 32'd0);
    check("b2b_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_dec_valid", 32'(rsp_valid), 32'd1);
    check("b2b_dec_result", 32'(rsp_result), 32'h7FFFF);
    check("b2b_dec_error", 32'(rsp_error), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_done_valid", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
